// File: rtl/cnn_3d_volume_loader.sv
// cnn_3d_volume_loader
//   Input stage of the 3D CNN pipeline. Collects an IMG_SIZE^3 voxel volume
//   from a valid/ready stream (raster order, x fastest, then y, then z) into
//   an on-chip buffer. It then presents that buffer through a registered
//   random-access read port and pulses start_out. The volume is held until
//   release_in, and malformed frames are dropped with a frame_err pulse.
//
//   Build option: define CNN_LOADER_PINGPONG_EN for two buffer banks. One
//   bank is read while the other fills. Undefined gives a single bank, and
//   the loader back-pressures while the volume is held.
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   s_valid      in   voxel beat valid
//   s_ready      out  loader can accept a beat (decoded from registered state)
//   s_data       in   signed voxel, DATA_WIDTH bits
//   s_last       in   final beat of the volume
//   rd_addr      in   read address z*IMG_SIZE^2 + y*IMG_SIZE + x
//   rd_data      out  registered read data (0 for rd_addr >= NUM_VOX)
//   frame_valid  out  a complete volume is held for reading
//   start_out    out  one-cycle pulse when a volume becomes readable
//   release_in   in   one-cycle pulse, consumer is done with the volume
//   frame_err    out  one-cycle pulse, malformed frame dropped
//   frame_count  out  number of accepted volumes, wraps at 16 bits
//   dbg_state_o  out  fill-side FSM state for observation
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready.
// s_ready depends only on registered state, so the source may hold s_valid
// and s_data stable until that edge without any combinational loop.

module cnn_3d_volume_loader #(
  parameter  int IMG_SIZE   = 6,
  parameter  int DATA_WIDTH = 16,
  localparam int NUM_VOX    = IMG_SIZE * IMG_SIZE * IMG_SIZE,
  localparam int AW         = $clog2(NUM_VOX)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  input  logic        [AW-1:0]         rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         frame_valid,
  output logic                         start_out,
  input  logic                         release_in,
  output logic                         frame_err,
  output logic        [15:0]           frame_count,
  output logic        [1:0]            dbg_state_o
);

`ifdef CNN_LOADER_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int MW = $clog2(NBANK * NUM_VOX);

  // S_LOCKED means the filling bank holds a complete volume and cannot take
  // more beats. With one bank that bank is also the read bank. With two
  // banks it is the pending bank that waits for the read port.
  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LOCKED = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            fill_bank_q, fill_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            valid_q, valid_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic [15:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [DATA_WIDTH-1:0] buf_mem [NBANK*NUM_VOX];

  logic            accept;
  logic            last_vox;
  logic            done;
  logic            wr_en;
  logic            rd_in_range;
  logic [MW-1:0]   wr_idx;
  logic [MW-1:0]   rd_idx;

  assign s_ready     = (state_q != S_LOCKED);
  assign accept      = s_valid && s_ready;
  assign last_vox    = (wr_cnt_q == AW'(NUM_VOX - 1));
  assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(NUM_VOX));
  assign wr_idx      = (fill_bank_q ? MW'(NUM_VOX) : MW'(0)) + MW'(wr_cnt_q);
  assign rd_idx      = (rd_bank_q   ? MW'(NUM_VOX) : MW'(0)) + MW'(rd_addr);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    fill_bank_d = fill_bank_q;
    rd_bank_d   = rd_bank_q;
    valid_d     = valid_q;
    start_d     = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;
    done        = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (last_vox) begin
            // Full count reached: completes with s_last, otherwise the
            // frame is overlong and the rest is discarded until s_last.
            wr_cnt_d = '0;
            if (s_last) done = 1'b1;
            else        state_d = S_FLUSH;
          end else if (s_last) begin
            err_d    = 1'b1;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (accept && s_last) begin
          err_d    = 1'b1;
          wr_cnt_d = '0;
          state_d  = S_FILL;
        end
      end
      S_LOCKED: ;
      default: state_d = S_FILL;
    endcase

`ifdef CNN_LOADER_PINGPONG_EN
    // Release is applied before a same-cycle completion, so a bank that
    // completes together with the release takes the read port at once.
    if (release_in && valid_q) begin
      if (state_q == S_LOCKED) begin
        rd_bank_d   = fill_bank_q;
        fill_bank_d = ~fill_bank_q;
        state_d     = S_FILL;
        start_d     = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (done) begin
      count_d = count_q + 16'd1;
      if (valid_d) begin
        state_d = S_LOCKED;
      end else begin
        rd_bank_d   = fill_bank_q;
        fill_bank_d = ~fill_bank_q;
        valid_d     = 1'b1;
        start_d     = 1'b1;
      end
    end
`else
    if (state_q == S_LOCKED && release_in) begin
      state_d  = S_FILL;
      valid_d  = 1'b0;
      wr_cnt_d = '0;
    end
    if (done) begin
      state_d = S_LOCKED;
      valid_d = 1'b1;
      start_d = 1'b1;
      count_d = count_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FILL;
      wr_cnt_q    <= '0;
      fill_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      fill_bank_q <= fill_bank_d;
      rd_bank_q   <= rd_bank_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      err_q       <= err_d;
      count_q     <= count_d;
      rd_data_q   <= rd_in_range ? buf_mem[rd_idx] : '0;
    end
  end

  // Buffer contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_idx] <= s_data;
  end

  assign rd_data     = rd_data_q;
  assign frame_valid = valid_q;
  assign start_out   = start_q;
  assign frame_err   = err_q;
  assign frame_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cnn_3d_volume_loader.sv
// Bench for cnn_3d_volume_loader: hand sequences, a table of frame shapes
// and randomized traffic, all checked each cycle against a frame-level model.
module tb_cnn_3d_volume_loader;
  localparam int NUM_VOX = 216;
  localparam int AW      = 8;
  localparam int DW      = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          frame_valid;
  logic          start_out;
  logic          release_in = 1'b0;
  logic          frame_err;
  logic [15:0]   frame_count;
  logic [1:0]    dbg_state_o;

  cnn_3d_volume_loader dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .start_out(start_out), .release_in(release_in),
    .frame_err(frame_err), .frame_count(frame_count), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  int n_errs   = 0;

  logic [DW-1:0] exp_q[$];        // expected rd_data values in flight
  logic [DW-1:0] m_q[$];          // beats of the frame being collected
  logic [DW-1:0] m_rd_mem[NUM_VOX];
  logic [DW-1:0] m_pend_mem[NUM_VOX];
  bit            m_flush  = 0;
  bit            m_locked = 0;
  bit            m_pend   = 0;
  int            m_count  = 0;

  typedef struct {
    int n;
    int last_at;
    int base;
    int exp_starts;
    int exp_errs;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef CNN_LOADER_PINGPONG_EN
    return !m_pend;
`else
    return !m_locked;
`endif
  endfunction

  // ---------------- driver: one clock cycle with model update ----------------
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l,
                       input bit rel, input logic [AW-1:0] addr);
    bit acc, rel_ok, got, e_start, e_err, rd_chk;
    s_valid = v; s_data = d; s_last = l; release_in = rel; rd_addr = addr;
    check("s_ready", s_ready, model_ready());
    rd_chk = 0;
    if (addr >= NUM_VOX) begin exp_q.push_back('0); rd_chk = 1; end
    else if (m_locked) begin exp_q.push_back(m_rd_mem[addr]); rd_chk = 1; end

    acc = v && model_ready();
    rel_ok = rel && m_locked;
    got = 0; e_start = 0; e_err = 0;
    if (acc) begin
      if (m_flush) begin
        if (l) begin m_flush = 0; e_err = 1; end
      end else begin
        m_q.push_back(d);
        if (l) begin
          if (m_q.size() == NUM_VOX) got = 1;
          else begin e_err = 1; m_q.delete(); end
        end else if (m_q.size() == NUM_VOX) begin
          m_flush = 1; m_q.delete();
        end
      end
    end
`ifdef CNN_LOADER_PINGPONG_EN
    if (rel_ok) begin
      if (m_pend) begin m_rd_mem = m_pend_mem; m_pend = 0; e_start = 1; end
      else m_locked = 0;
    end
    if (got) begin
      m_count++;
      if (m_locked) begin
        for (int i = 0; i < NUM_VOX; i++) m_pend_mem[i] = m_q[i];
        m_pend = 1;
      end else begin
        for (int i = 0; i < NUM_VOX; i++) m_rd_mem[i] = m_q[i];
        m_locked = 1; e_start = 1;
      end
    end
`else
    if (rel_ok) m_locked = 0;
    if (got) begin
      for (int i = 0; i < NUM_VOX; i++) m_rd_mem[i] = m_q[i];
      m_locked = 1; e_start = 1; m_count++;
    end
`endif
    if (got) m_q.delete();

    @(posedge clk); #1;
    check("frame_valid", frame_valid, m_locked);
    check("start_out", start_out, e_start);
    check("frame_err", frame_err, e_err);
    check("frame_count", frame_count, 32'(m_count[15:0]));
    if (rd_chk) check("rd_data", rd_data, exp_q.pop_front());
    n_starts += int'(start_out);
    n_errs   += int'(frame_err);
  endtask

  task automatic idle(input bit rel, input logic [AW-1:0] addr);
    cycle(1'b0, '0, 1'b0, rel, addr);
  endtask

  task automatic send_frame(input int n, input int last_at, input int base);
    for (int i = 0; i < n; i++)
      cycle(1'b1, DW'(base + i), (i == last_at), 1'b0, AW'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    s_valid = 0; s_last = 0; release_in = 0; s_data = '0; rd_addr = '0;
    reset_n = 1'b0;
    #1;
    check("rst_frame_valid", frame_valid, 0);
    check("rst_start_out", start_out, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_count", frame_count, 0);
    m_q.delete(); exp_q.delete();
    m_flush = 0; m_locked = 0; m_pend = 0; m_count = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0, e0;
    logic [15:0] c0;
    bit l;

    vecs[0] = '{216, 215,    0, 1, 0};  // clean
    vecs[1] = '{100,  99,  100, 0, 1};  // early last on beat 99
    vecs[2] = '{216, 215, 1000, 1, 0};  // clean after error
    vecs[3] = '{219, 218, 7000, 0, 1};  // missing last, last on 3rd extra beat
    vecs[4] = '{  1,   0,  900, 0, 1};  // last on very first beat
    vecs[5] = '{216, 215, 5000, 1, 0};  // clean

    #2;
    do_reset();

    // Clean frame with data = index.
    send_frame(216, 215, 0);
    check("start_after_last", start_out, 1);
    check("count_after_clean", frame_count, 1);
    idle(1'b0, 8'd37);
    check("start_one_cycle", start_out, 0);
    check("rd_37", rd_data, 37);
    idle(1'b0, 8'd250);
    check("rd_out_of_range", rd_data, 0);

`ifdef CNN_LOADER_PINGPONG_EN
    // Second frame streams in while the first is held.
    send_frame(216, 215, 3000);
    check("pp_ready_low_pending", s_ready, 0);
    check("pp_valid_held", frame_valid, 1);
    idle(1'b1, 8'd0);
    check("pp_start_after_release", start_out, 1);
    check("pp_valid_stays", frame_valid, 1);
    idle(1'b0, 8'd0);
    check("pp_rd_second_frame", rd_data, 3000);
    idle(1'b1, 8'd0);
    check("pp_valid_drops", frame_valid, 0);
`else
    // Backpressure: beats offered while locked must not be taken.
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(1000 + i), 1'b0, 1'b0, 8'd3);
    check("bp_ready_low", s_ready, 0);
    idle(1'b0, 8'd0);
    check("bp_no_overwrite", rd_data, 0);
    idle(1'b1, 8'd0);
    check("bp_valid_falls", frame_valid, 0);
    check("bp_ready_back", s_ready, 1);
    send_frame(216, 215, 1000);
    idle(1'b0, 8'd5);
    check("bp_rd_second_frame", rd_data, 1005);
    idle(1'b1, 8'd0);
`endif

    // Table of frame shapes.
    for (int k = 0; k < 6; k++) begin
      if (m_locked) idle(1'b1, 8'd0);
      s0 = n_starts; e0 = n_errs; c0 = frame_count;
      send_frame(vecs[k].n, vecs[k].last_at, vecs[k].base);
      idle(1'b0, 8'd200);
      idle(1'b0, 8'd0);
      check($sformatf("vec%0d_starts", k), n_starts - s0, vecs[k].exp_starts);
      check($sformatf("vec%0d_errs", k), n_errs - e0, vecs[k].exp_errs);
      check($sformatf("vec%0d_count", k), 32'(frame_count - c0), vecs[k].exp_starts);
      if (vecs[k].exp_starts == 1) begin
        idle(1'b0, 8'd17);
        check($sformatf("vec%0d_rd17", k), rd_data, vecs[k].base + 17);
      end
    end
    if (m_locked) idle(1'b1, 8'd0);

    // Reset in the middle of a fill.
    send_frame(121, -1, 500);
    do_reset();
    s0 = n_starts;
    send_frame(216, 215, 2000);
    idle(1'b0, 8'd120);
    check("rst_mid_rd120", rd_data, 2120);
    idle(1'b0, 8'd0);
    check("rst_mid_one_start", n_starts - s0, 1);
    check("rst_mid_count", frame_count, 1);
    idle(1'b1, 8'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      if (m_flush)                   l = ($urandom_range(0, 3) == 0);
      else if (m_q.size() == NUM_VOX - 1) l = ($urandom_range(0, 9) != 0);
      else                           l = ($urandom_range(0, 299) == 0);
      cycle(($urandom_range(0, 9) < 8), DW'($urandom_range(0, 65535)), l,
            ($urandom_range(0, 39) == 0), AW'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
